// File: rtl/bp_me_nonsynth_lce_tr_replay.sv
// Trace-replay driver for the mock LCE. It walks a ROM of {opcode, packet}
// records, issues commands on the tr_pkt output channel, and checks responses
// against expected packets. The result is a sticky done or error flag.
module bp_me_nonsynth_lce_tr_replay #(
  parameter int tr_ring_width_p  = 123,
  parameter int rom_addr_width_p = 10,
  parameter int timeout_cycles_p = 4096,
  parameter int lce_id_p         = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  output logic [rom_addr_width_p-1:0]   rom_addr_o,
  input  logic [tr_ring_width_p+4-1:0]  rom_data_i,
  output logic [tr_ring_width_p-1:0]    tr_pkt_o,
  output logic                          tr_pkt_v_o,
  input  logic                          tr_pkt_yumi_i,
  input  logic [tr_ring_width_p-1:0]    tr_pkt_i,
  input  logic                          tr_pkt_v_i,
  output logic                          tr_pkt_ready_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam int to_w = $clog2(timeout_cycles_p) + 1;
  localparam logic [to_w-1:0] to_last = to_w'(timeout_cycles_p - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_SEND, S_RECV, S_WAIT, S_DONE, S_ERROR
  } state_e;

  state_e                        state_r, state_n;
  logic [rom_addr_width_p-1:0]   rom_addr_r;
  logic [tr_ring_width_p-1:0]    pkt_r, exp_r;
  logic [15:0]                   wait_cnt;
  logic [to_w-1:0]               to_cnt;

  logic [3:0]                    opcode;
  logic [tr_ring_width_p-1:0]    rec_pkt;
  logic adv, addr_inc, ld_pkt, ld_exp, ld_wait, to_inc;

  assign opcode  = rom_data_i[tr_ring_width_p+3 -: 4];
  assign rec_pkt = rom_data_i[tr_ring_width_p-1:0];

  assign rom_addr_o     = rom_addr_r;
  assign tr_pkt_o       = pkt_r;
  assign tr_pkt_v_o     = (state_r == S_SEND);
  assign tr_pkt_ready_o = (state_r == S_RECV);
  assign done_o         = (state_r == S_DONE);
  assign error_o        = (state_r == S_ERROR);

  // Advancing past the last ROM slot is treated as a trace fault, not a wrap.
  assign addr_inc = adv && !(&rom_addr_r);

  // Next-state decode: record interpretation in FETCH, handshakes elsewhere
  always_comb begin
    state_n = state_r;
    adv     = 1'b0;
    ld_pkt  = 1'b0;
    ld_exp  = 1'b0;
    ld_wait = 1'b0;
    to_inc  = 1'b0;
    unique case (state_r)
      S_FETCH: begin
        unique case (opcode)
          4'b0000: adv = 1'b1;
          4'b0001: begin ld_pkt = 1'b1; state_n = S_SEND; end
          4'b0010: begin ld_exp = 1'b1; state_n = S_RECV; end
          4'b0011: begin
            if (rec_pkt[15:0] == 16'd0) adv = 1'b1;
            else begin ld_wait = 1'b1; state_n = S_WAIT; end
          end
          4'b0100: state_n = S_DONE;
          default: state_n = S_ERROR;
        endcase
      end
      S_SEND: begin
        if (tr_pkt_yumi_i) begin adv = 1'b1; state_n = S_FETCH; end
      end
      S_RECV: begin
        if (tr_pkt_v_i) begin
          if (tr_pkt_i == exp_r) begin adv = 1'b1; state_n = S_FETCH; end
          else state_n = S_ERROR;
        end else if (to_cnt == to_last) begin
          state_n = S_ERROR;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 16'd1) begin adv = 1'b1; state_n = S_FETCH; end
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_ERROR;
    endcase
    if (adv && (&rom_addr_r)) state_n = S_ERROR;
  end

  // State, address, latched packets and counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= S_FETCH;
      rom_addr_r <= '0;
      pkt_r      <= '0;
      exp_r      <= '0;
      wait_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      state_r <= state_n;
      if (addr_inc) rom_addr_r <= rom_addr_r + 1'b1;
      if (ld_pkt)   pkt_r      <= rec_pkt;
      if (ld_exp) begin
        exp_r  <= rec_pkt;
        to_cnt <= '0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (ld_wait) wait_cnt <= rec_pkt[15:0];
      else if (state_r == S_WAIT) wait_cnt <= wait_cnt - 16'd1;
    end
  end

endmodule
